// File: rtl/modem_transmitter.sv
// Baseband I/Q frame generator: BPSK preamble, PRBS-9 QPSK data field, idle gap.
// One complex sample per clock, all outputs registered.
module modem_transmitter #(
  parameter int unsigned       DAT_W    = 12,
  parameter int unsigned       AMP      = 1448,
  parameter int unsigned       PRE_LEN  = 64,
  parameter logic [PRE_LEN-1:0] PREAMBLE = 64'hA5A5_0F0F_3C3C_9669,
  parameter int unsigned       DATA_LEN = 1024,
  parameter int unsigned       GAP_LEN  = 64
) (
  input  logic                    iclk,
  input  logic                    irst,
  input  logic                    ien_data,
  output logic                    osop_IQ,
  output logic signed [DAT_W-1:0] odata_I,
  output logic signed [DAT_W-1:0] odata_Q,
  output logic [1:0]              a,
  output logic                    owrite_en
);

  localparam int unsigned CNT_MAX_A = (PRE_LEN > DATA_LEN) ? PRE_LEN : DATA_LEN;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > GAP_LEN) ? CNT_MAX_A : GAP_LEN;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PIDX_W    = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam int unsigned PRBS_W    = 9;

  localparam logic [DAT_W-1:0]  C_POS     = DAT_W'(AMP);
  localparam logic [DAT_W-1:0]  C_NEG     = DAT_W'(0) - C_POS;
  localparam logic [CNT_W-1:0]  C_PRE_END = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0]  C_DAT_END = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0]  C_GAP_END = CNT_W'(GAP_LEN - 1);
  localparam logic [PRBS_W-1:0] C_SEED    = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PRBS_W-1:0]   r_prbs;
  logic                r_sop;
  logic                r_we;
  logic [DAT_W-1:0]    r_i;
  logic [DAT_W-1:0]    r_q;
  logic [1:0]          r_a;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [PRBS_W-1:0]   w_prbs_nxt;
  logic                w_sop_nxt;
  logic                w_we_nxt;
  logic [DAT_W-1:0]    w_i_nxt;
  logic [DAT_W-1:0]    w_q_nxt;
  logic [1:0]          w_a_nxt;
  logic                w_pre_bit;

  // Two PRBS steps per data symbol: first bit drives I, second drives Q
  logic                w_fb_i;
  logic                w_fb_q;
  logic [PRBS_W-1:0]   w_s1;
  logic [PRBS_W-1:0]   w_s2;

  assign w_fb_i = r_prbs[8] ^ r_prbs[4];
  assign w_s1   = {r_prbs[7:0], w_fb_i};
  assign w_fb_q = w_s1[8] ^ w_s1[4];
  assign w_s2   = {w_s1[7:0], w_fb_q};

  assign w_pre_bit = PREAMBLE[w_cnt_nxt[PIDX_W-1:0]];

  // Next state/counter, then the sample that the next state will present
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_prbs_nxt  = r_prbs;
    w_sop_nxt   = 1'b0;
    w_we_nxt    = 1'b0;
    w_i_nxt     = '0;
    w_q_nxt     = '0;
    w_a_nxt     = 2'b00;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (ien_data) w_state_nxt = ST_PRE;
      end
      ST_PRE: begin
        if (r_cnt == C_PRE_END) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (r_cnt == C_DAT_END) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (r_cnt == C_GAP_END) begin
          w_state_nxt = ien_data ? ST_PRE : ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    case (w_state_nxt)
      ST_PRE: begin
        w_prbs_nxt = C_SEED;
        w_we_nxt   = 1'b1;
        w_sop_nxt  = (w_cnt_nxt == '0);
        w_i_nxt    = w_pre_bit ? C_NEG : C_POS;
        w_q_nxt    = w_pre_bit ? C_NEG : C_POS;
      end
      ST_DATA: begin
        w_prbs_nxt = w_s2;
        w_we_nxt   = 1'b1;
        w_i_nxt    = w_fb_i ? C_NEG : C_POS;
        w_q_nxt    = w_fb_q ? C_NEG : C_POS;
        w_a_nxt    = {w_fb_i, w_fb_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_prbs  <= C_SEED;
      r_sop   <= 1'b0;
      r_we    <= 1'b0;
      r_i     <= '0;
      r_q     <= '0;
      r_a     <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prbs  <= w_prbs_nxt;
      r_sop   <= w_sop_nxt;
      r_we    <= w_we_nxt;
      r_i     <= w_i_nxt;
      r_q     <= w_q_nxt;
      r_a     <= w_a_nxt;
    end
  end

  assign osop_IQ   = r_sop;
  assign owrite_en = r_we;
  assign odata_I   = r_i;
  assign odata_Q   = r_q;
  assign a         = r_a;

endmodule

// File: tb/tb_modem_transmitter.sv
// Directed self-checking bench for modem_transmitter: reset, frame layout, repeat, stop, mid-frame reset.
module tb_modem_transmitter;

  localparam int unsigned DAT_W    = 12;
  localparam int unsigned PRE_LEN  = 64;
  localparam int unsigned DATA_LEN = 1024;
  localparam int unsigned GAP_LEN  = 64;
  localparam logic [63:0] PRE_PAT  = 64'hA5A5_0F0F_3C3C_9669;
  localparam logic [11:0] POS      = 12'h5A8;
  localparam logic [11:0] NEG      = 12'hA58;

  logic                    iclk = 1'b0;
  logic                    irst;
  logic                    ien_data;
  logic                    osop_IQ;
  logic signed [DAT_W-1:0] odata_I;
  logic signed [DAT_W-1:0] odata_Q;
  logic [1:0]              a;
  logic                    owrite_en;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned sop_cyc;

  logic [11:0] ref_i [DATA_LEN];
  logic [11:0] ref_q [DATA_LEN];
  logic [1:0]  ref_a [DATA_LEN];

  modem_transmitter dut (
    .iclk      (iclk),
    .irst      (irst),
    .ien_data  (ien_data),
    .osop_IQ   (osop_IQ),
    .odata_I   (odata_I),
    .odata_Q   (odata_Q),
    .a         (a),
    .owrite_en (owrite_en)
  );

  always #5 iclk = ~iclk;

  task automatic step();
    @(posedge iclk);
    #1;
    cyc++;
  endtask

  function automatic logic [11:0] amp_of(input logic b);
    return b ? NEG : POS;
  endfunction

  task automatic test_reset();
    irst = 1'b1;
    ien_data = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_vec++;
      if ({osop_IQ, owrite_en, a, odata_I, odata_Q} !== 28'd0) begin
        n_err++;
        $display("FAIL reset cyc%0d: sop=%b we=%b a=%b I=%h Q=%h, need all 0",
                 c, osop_IQ, owrite_en, a, odata_I, odata_Q);
      end
    end
  endtask

  // Frame 1: latency, preamble, data (model + hand values), gap
  task automatic test_frame();
    logic [8:0] s;
    logic       bi, bq;
    logic [1:0] hand_a [3];
    hand_a[0] = 2'b00; hand_a[1] = 2'b00; hand_a[2] = 2'b01;
    irst = 1'b0;
    step();
    sop_cyc = cyc;
    n_vec++;
    if (osop_IQ !== 1'b1 || owrite_en !== 1'b1 || odata_I !== NEG || odata_Q !== NEG || a !== 2'b00) begin
      n_err++;
      $display("FAIL start: sop=%b we=%b I=%h Q=%h a=%b, need 1 1 a58 a58 00",
               osop_IQ, owrite_en, odata_I, odata_Q, a);
    end
    for (int k = 1; k < PRE_LEN; k++) begin
      step();
      n_vec++;
      if (osop_IQ !== 1'b0 || owrite_en !== 1'b1 || a !== 2'b00 ||
          odata_I !== amp_of(PRE_PAT[k]) || odata_Q !== amp_of(PRE_PAT[k])) begin
        n_err++;
        $display("FAIL pre%0d: sop=%b we=%b a=%b I=%h Q=%h, need 0 1 00 %h %h",
                 k, osop_IQ, owrite_en, a, odata_I, odata_Q, amp_of(PRE_PAT[k]), amp_of(PRE_PAT[k]));
      end
    end
    s = 9'h1FF;
    for (int m = 0; m < DATA_LEN; m++) begin
      bi = s[8] ^ s[4]; s = {s[7:0], bi};
      bq = s[8] ^ s[4]; s = {s[7:0], bq};
      ref_i[m] = amp_of(bi);
      ref_q[m] = amp_of(bq);
      ref_a[m] = {bi, bq};
      step();
      n_vec++;
      if (osop_IQ !== 1'b0 || owrite_en !== 1'b1 || a !== ref_a[m] ||
          odata_I !== ref_i[m] || odata_Q !== ref_q[m]) begin
        n_err++;
        $display("FAIL data%0d: sop=%b we=%b a=%b I=%h Q=%h, need 0 1 %b %h %h",
                 m, osop_IQ, owrite_en, a, odata_I, odata_Q, ref_a[m], ref_i[m], ref_q[m]);
      end
      if (m < 3) begin
        n_vec++;
        if (a !== hand_a[m] || odata_I !== amp_of(hand_a[m][1]) || odata_Q !== amp_of(hand_a[m][0])) begin
          n_err++;
          $display("FAIL hand_data%0d: a=%b I=%h Q=%h, need a=%b", m, a, odata_I, odata_Q, hand_a[m]);
        end
      end
    end
    for (int g = 0; g < GAP_LEN; g++) begin
      step();
      n_vec++;
      if ({osop_IQ, owrite_en, a, odata_I, odata_Q} !== 28'd0) begin
        n_err++;
        $display("FAIL gap%0d: sop=%b we=%b a=%b I=%h Q=%h, need all 0",
                 g, osop_IQ, owrite_en, a, odata_I, odata_Q);
      end
    end
  endtask

  // Frame 2 follows immediately; enable is dropped mid-data so it is the last
  task automatic test_back_to_back();
    step();
    n_vec++;
    if (osop_IQ !== 1'b1 || (cyc - sop_cyc) !== 1152 || odata_I !== NEG) begin
      n_err++;
      $display("FAIL sop2: sop=%b period=%0d I=%h, need 1 1152 a58", osop_IQ, cyc - sop_cyc, odata_I);
    end
    for (int k = 1; k < PRE_LEN; k++) begin
      step();
      n_vec++;
      if (osop_IQ !== 1'b0 || owrite_en !== 1'b1 ||
          odata_I !== amp_of(PRE_PAT[k]) || odata_Q !== amp_of(PRE_PAT[k])) begin
        n_err++;
        $display("FAIL pre2_%0d: sop=%b we=%b I=%h Q=%h, need 0 1 %h",
                 k, osop_IQ, owrite_en, odata_I, odata_Q, amp_of(PRE_PAT[k]));
      end
    end
    for (int m = 0; m < DATA_LEN; m++) begin
      step();
      if (m == 100) ien_data = 1'b0;
      n_vec++;
      if (owrite_en !== 1'b1 || a !== ref_a[m] || odata_I !== ref_i[m] || odata_Q !== ref_q[m]) begin
        n_err++;
        $display("FAIL data2_%0d: we=%b a=%b I=%h Q=%h, need 1 %b %h %h",
                 m, owrite_en, a, odata_I, odata_Q, ref_a[m], ref_i[m], ref_q[m]);
      end
    end
    for (int g = 0; g < GAP_LEN; g++) begin
      step();
      n_vec++;
      if ({osop_IQ, owrite_en, a, odata_I, odata_Q} !== 28'd0) begin
        n_err++;
        $display("FAIL gap2_%0d: sop=%b we=%b I=%h, need all 0", g, osop_IQ, owrite_en, odata_I);
      end
    end
  endtask

  task automatic test_stop();
    for (int c = 0; c < 40; c++) begin
      step();
      n_vec++;
      if ({osop_IQ, owrite_en, a, odata_I, odata_Q} !== 28'd0) begin
        n_err++;
        $display("FAIL stop%0d: sop=%b we=%b a=%b I=%h Q=%h, need all 0",
                 c, osop_IQ, owrite_en, a, odata_I, odata_Q);
      end
    end
  endtask

  task automatic test_midreset();
    ien_data = 1'b1;
    step();
    n_vec++;
    if (osop_IQ !== 1'b1 || odata_I !== NEG) begin
      n_err++;
      $display("FAIL restart_sop: sop=%b I=%h, need 1 a58", osop_IQ, odata_I);
    end
    repeat (PRE_LEN - 1 + 10) step();
    n_vec++;
    if (owrite_en !== 1'b1 || a !== ref_a[9]) begin
      n_err++;
      $display("FAIL predrop_data9: we=%b a=%b, need 1 %b", owrite_en, a, ref_a[9]);
    end
    irst = 1'b1;
    step();
    irst = 1'b0;
    n_vec++;
    if ({osop_IQ, owrite_en, a, odata_I, odata_Q} !== 28'd0) begin
      n_err++;
      $display("FAIL midreset: sop=%b we=%b a=%b I=%h Q=%h, need all 0",
               osop_IQ, owrite_en, a, odata_I, odata_Q);
    end
    step();
    n_vec++;
    if (osop_IQ !== 1'b1 || owrite_en !== 1'b1 || odata_I !== NEG || odata_Q !== NEG) begin
      n_err++;
      $display("FAIL post_reset_sop: sop=%b we=%b I=%h Q=%h, need 1 1 a58 a58",
               osop_IQ, owrite_en, odata_I, odata_Q);
    end
    repeat (PRE_LEN - 1) step();
    for (int m = 0; m < 3; m++) begin
      step();
      n_vec++;
      if (a !== ref_a[m] || odata_I !== ref_i[m] || odata_Q !== ref_q[m]) begin
        n_err++;
        $display("FAIL reseed_data%0d: a=%b I=%h Q=%h, need %b %h %h",
                 m, a, odata_I, odata_Q, ref_a[m], ref_i[m], ref_q[m]);
      end
    end
  endtask

  initial begin
    irst = 1'b1;
    ien_data = 1'b0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_stop();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/modem_transmitter.md
Name: modem_transmitter

Overview:
- Baseband I/Q frame generator for the modem transmit path. It feeds the DAC interface.
- Each frame carries a fixed BPSK preamble, then QPSK data symbols from an internal PRBS-9, then an idle gap.
- Emits one complex sample per clock with a write-enable and a start-of-packet strobe.

Parameters:
- DAT_W, 12, width of signed I and Q output samples.
- AMP, 1448, constellation amplitude (about 0.707 of full scale at 12 bits).
- PRE_LEN, 64, number of preamble samples per frame.
- PREAMBLE, 64'hA5A5_0F0F_3C3C_9669, preamble bit pattern, consumed LSB first.
- DATA_LEN, 1024, number of QPSK data samples per frame.
- GAP_LEN, 64, number of idle cycles after the data field.

Ports:
- iclk, in, 1, system clock; all logic on the rising edge.
- irst, in, 1, synchronous active-high reset.
- ien_data, in, 1, transmit enable; sampled only at frame boundaries.
- osop_IQ, out, 1, one-cycle pulse coincident with the first preamble sample.
- odata_I, out, DAT_W, signed in-phase sample.
- odata_Q, out, DAT_W, signed quadrature sample.
- a, out, 2, debug: {I bit, Q bit} of the current data symbol; 0 outside the data field.
- owrite_en, out, 1, high when odata_I/odata_Q hold a valid sample (preamble and data fields).

Behaviour:
- Reset (irst=1 at a clock edge):
  - state goes to IDLE; sample counter goes to 0; PRBS register s[8:0] goes to 9'h1FF.
  - All outputs are 0 on the next edge.
- States: IDLE, PRE, DATA, GAP. All outputs are registered.
- IDLE:
  - Outputs are 0.
  - If ien_data=1, the next edge enters PRE and presents preamble sample 0, so latency is 1 cycle.
- PRE, sample k = 0..PRE_LEN-1:
  - PREAMBLE[k]=0 gives odata_I = odata_Q = +AMP; PREAMBLE[k]=1 gives -AMP on both.
  - owrite_en=1; osop_IQ=1 only for k=0; a=0.
  - After the last sample, go to DATA.
- DATA, sample m = 0..DATA_LEN-1:
  - The PRBS is stepped twice per sample.
  - Step rule: fb = s[8]^s[4]; s <= {s[7:0], fb}; the emitted bit is fb.
  - First emitted bit is bI, second is bQ.
  - odata_I = bI ? -AMP : +AMP; odata_Q = bQ ? -AMP : +AMP; a = {bI, bQ}; owrite_en=1.
- GAP:
  - GAP_LEN cycles with all outputs 0 and owrite_en=0.
  - On the last gap cycle, sample ien_data:
    - 1 → next edge is PRE sample 0 of a new frame (back-to-back frames, period PRE_LEN+DATA_LEN+GAP_LEN).
    - 0 → IDLE.
- PRBS reseed: s is reloaded to 9'h1FF on entry to PRE, so every frame's data field is identical.
- Enable timing: ien_data deasserting mid-frame has no effect; the current frame completes, including the gap.
- Reset mid-frame: abort immediately; the next edge shows all-zero outputs and IDLE.
- Arithmetic: ±AMP are DAT_W-bit two's complement constants; no saturation is needed. -AMP = -1448 = 12'hA58.
- Counter: width ceil(log2(max(PRE_LEN, DATA_LEN, GAP_LEN))) bits; it wraps to 0 at each state change.

Test Plan:
- Reset: hold irst=1 for 5 cycles with ien_data=1 → osop_IQ, owrite_en, a, odata_I, odata_Q all 0 throughout.
- Start latency: release reset, ien_data=1 → the cycle after the first enabled edge has osop_IQ=1, owrite_en=1, odata_I = odata_Q = -AMP (PREAMBLE[0]=1); osop_IQ low for the rest of the frame.
- Data mapping:
  - Data sample 0: a=2'b00, I=Q=+1448.
  - Data sample 1: a=2'b00, I=Q=+1448.
  - Data sample 2: a=2'b01, I=+1448, Q=-1448.
  - Field length: owrite_en high for exactly 64+1024 consecutive cycles.
- Gap and repeat: ien_data held 1 → 64 cycles with owrite_en=0, then a new osop_IQ; samples of frame 2 identical to frame 1. osop_IQ period is 1152 cycles.
- Stop: drop ien_data during DATA of frame 1 → frame 1 completes, including its gap; no second osop_IQ; outputs stay 0.
- Mid-frame reset: assert irst for 1 cycle during DATA → outputs 0 on the next edge. After release with ien_data=1, the frame restarts at preamble sample 0 with the PRBS reseeded (data sample 0 again a=2'b00).
